// File: rtl/rr_mux_arbiter_pkg.sv
// arb_pkg: shared types and helpers for the round-robin mux arbiter.
//   arb_state_t  : FSM state encoding (IDLE / BUSY)
//   ARB_*_DEFAULT: default sizing used by the top and its interface
//   next_rr()    : rotating-priority winner search over up to 8 requesters
package arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  localparam int ARB_N_DEFAULT     = 4;
  localparam int ARB_WIDTH_DEFAULT = 64;

  // First set bit of req searching ptr, ptr+1, ... mod n. Inputs are
  // zero-padded to 8 bits so one function serves every legal N.
  // Returns ptr when nothing is requested; callers gate on |req.
  function automatic logic [2:0] next_rr(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int n);
    logic [2:0] idx;
    logic       found;
    next_rr = ptr;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        next_rr = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: request/data/grant bundle between requesters and the
// arbiter.
//   req, data_in      : requester side -> arbiter
//   grant, sel        : registered ownership
//   out_data/out_valid: forwarded word of the current owner
//   expired           : forced-release pulse (hold-limit build only)
interface rr_mux_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 64
);
  logic [N-1:0]         req;
  logic [N*WIDTH-1:0]   data_in;
  logic [N-1:0]         grant;
  logic [$clog2(N)-1:0] sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 expired;

  modport master (output req, data_in,
                  input  grant, sel, out_data, out_valid, expired);
  modport slave  (input  req, data_in,
                  output grant, sel, out_data, out_valid, expired);
endinterface

// File: rtl/rr_mux_arbiter_word_mux.sv
// word_mux_nto1: N:1 word multiplexer built as a binary tree of 2:1 cells.
//   sel      : binary index, LSB steers the level nearest the inputs
//   data_in  : flattened words, word i at [i*WIDTH +: WIDTH]
//   data_out : selected word
module word_mux_nto1 #(
  parameter int N     = 4,
  parameter int WIDTH = 64
) (
  input  logic [$clog2(N)-1:0] sel,
  input  logic [N*WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]     data_out
);
  localparam int L = $clog2(N);

  // Heap-ordered tree: node 1 is the root, leaves are nodes N..2N-1,
  // node k picks between children 2k (sel bit 0) and 2k+1 (sel bit 1).
  logic [WIDTH-1:0] node [1:2*N-1];

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign node[N+i] = data_in[i*WIDTH +: WIDTH];
  end

  for (genvar k = 1; k < N; k++) begin : g_cell
    localparam int D = $clog2(k + 1) - 1;  // depth of node k, root = 0
    assign node[k] = sel[L-1-D] ? node[2*k+1] : node[2*k];
  end

  assign data_out = node[1];
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner selection for one shared WIDTH-bit path.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus (slave): req/data_in in; grant/sel/out_data/out_valid/expired out
// Optional build macro ARB_HOLD_LIMIT_EN: evicts an owner after MAX_HOLD
// grant cycles when someone else is waiting; expired pulses on eviction.
//
// state | meaning
// IDLE  | no owner, grant=0, next edge grants the rotation winner
// BUSY  | grant[sel] owns the path until req[sel] drops (or eviction)
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEFAULT,
  parameter int WIDTH    = ARB_WIDTH_DEFAULT,
  parameter int MAX_HOLD = 16
) (
  input logic             clk,
  input logic             reset,
  rr_mux_arbiter_if.slave bus
);
  localparam int SW = $clog2(N);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          expired_q, expired_d;
  logic [N-1:0]  others;
  logic [SW-1:0] win;
  logic          force_rel;
  logic [WIDTH-1:0] mux_word;

`ifdef ARB_HOLD_LIMIT_EN
  // Grant cycles left, loaded at grant; 0 means the owner has used MAX_HOLD.
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(MAX_HOLD - 1);
  logic [HW-1:0] hold_q, hold_d;
`else
  wire unused_max_hold = |MAX_HOLD;
`endif

  function automatic logic [SW-1:0] pick(input logic [N-1:0] r,
                                         input logic [SW-1:0] p);
    logic [7:0] rp;
    logic [2:0] pp;
    rp = '0;
    pp = '0;
    rp[N-1:0]  = r;
    pp[SW-1:0] = p;
    return SW'(next_rr(rp, pp, N));
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    expired_d = 1'b0;
    win       = '0;
    force_rel = 1'b0;
    // The owner's bit is masked so a handover never re-picks the owner.
    others    = bus.req & ~grant_q;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d    = hold_q;
    force_rel = (state_q == BUSY) && bus.req[sel_q] && (hold_q == '0) && (|others);
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win        = pick(bus.req, ptr_q);
          state_d    = BUSY;
          grant_d    = '0;
          grant_d[win] = 1'b1;
          sel_d      = win;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d     = HOLD_INIT;
`endif
        end
      end
      BUSY: begin
        if (bus.req[sel_q] && !force_rel) begin
`ifdef ARB_HOLD_LIMIT_EN
          hold_d = (hold_q == '0) ? hold_q : hold_q - 1'b1;
`endif
        end else begin
          // Release (voluntary or evicted): rotate past the old owner.
          ptr_d     = sel_q + SW'(1);
          expired_d = force_rel;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d    = HOLD_INIT;
`endif
          if (|others) begin
            win          = pick(others, sel_q + SW'(1));
            grant_d      = '0;
            grant_d[win] = 1'b1;
            sel_d        = win;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      expired_q <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q    <= HOLD_INIT;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      expired_q <= expired_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  word_mux_nto1 #(.N(N), .WIDTH(WIDTH)) u_word_mux (
    .sel      (sel_q),
    .data_in  (bus.data_in),
    .data_out (mux_word)
  );

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.expired   = expired_q;
  assign bus.out_valid = (state_q == BUSY) && bus.req[sel_q];
  assign bus.out_data  = bus.out_valid ? mux_word : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(grant_q));
      if (state_q == BUSY) assert (grant_q[sel_q]);
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;
  localparam logic [63:0] W0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] W2 = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] W3 = 64'h4444_4444_4444_4444;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rr_mux_arbiter_if #(.N(4), .WIDTH(64)) bus();

  rr_mux_arbiter #(.N(4), .WIDTH(64), .MAX_HOLD(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  g;
    logic [1:0]  s;
    logic        chk_s;
    logic        v;
    logic [63:0] d;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] m;
    int o;

    //            rst   req      grant    sel  chk  v     data
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 64'h0};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 64'h0};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 64'h0};
    vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 64'h0};
    vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, W2};
    vecs[7]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, W2};
    vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 64'h0};
    vecs[9]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, W1};
    vecs[10] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1, W3};
    vecs[11] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1, W3};
    vecs[12] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, W0};
    vecs[13] = '{1'b1, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 64'h0};
    vecs[14] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1, W0};
    vecs[15] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, W1};
    vecs[16] = '{1'b1, 4'b0011, 4'b0000, 2'd0, 1'b1, 1'b0, 64'h0};
    vecs[17] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1, W0};

    bus.req     = 4'b0000;
    bus.data_in = {W3, W2, W1, W0};

    for (int i = 0; i < 18; i++) begin
      reset   = vecs[i].rst;
      bus.req = vecs[i].req;
      tick();
      chk($sformatf("v%0d grant", i), 64'(bus.grant), 64'(vecs[i].g));
      if (vecs[i].chk_s) chk($sformatf("v%0d sel", i), 64'(bus.sel), 64'(vecs[i].s));
      chk($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].v));
      chk($sformatf("v%0d out_data", i), bus.out_data, vecs[i].d);
      chk($sformatf("v%0d expired", i), 64'(bus.expired), 64'h0);
    end
    reset = 1'b0;

    // Drop in the same cycle the grant registers: grant visible, no valid.
    bus.req = 4'b0000;
    do_reset();
    bus.req = 4'b0010;
    tick();
    chk("late_drop grant", 64'(bus.grant), 64'b0010);
    bus.req = 4'b0000;
    #1;
    chk("release_cycle grant", 64'(bus.grant), 64'b0010);
    chk("release_cycle out_valid", 64'(bus.out_valid), 64'h0);
    chk("release_cycle out_data", bus.out_data, 64'h0);
    tick();
    chk("after_release grant", 64'(bus.grant), 64'h0);

    // A pulse that never spans a rising edge is ignored.
    bus.req = 4'b0100;
    #3;
    bus.req = 4'b0000;
    tick();
    chk("glitch grant", 64'(bus.grant), 64'h0);
    chk("glitch out_valid", 64'(bus.out_valid), 64'h0);

    // All four requesting: strict rotation 0,1,2,3,0 with no idle cycle.
    do_reset();
    bus.req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      o = i % 4;
      m = 4'b0001 << o;
      chk($sformatf("rot%0d grant", i), 64'(bus.grant), 64'(m));
      chk($sformatf("rot%0d sel", i), 64'(bus.sel), 64'(o));
      chk($sformatf("rot%0d out_valid", i), 64'(bus.out_valid), 64'h1);
      if (i < 4) begin
        for (int c = 0; c < 2; c++) begin
          tick();
          chk($sformatf("rot%0d hold%0d", i, c), 64'(bus.grant), 64'(m));
        end
        bus.req = 4'b1111 & ~m;
        #1;
        chk($sformatf("rot%0d drop out_valid", i), 64'(bus.out_valid), 64'h0);
        tick();
        bus.req = 4'b1111;
      end
    end

    // Long hold by requester 0 with requester 2 arriving in grant cycle 5.
    bus.req = 4'b0000;
    do_reset();
    bus.req = 4'b0001;
    tick();
    chk("hold c1 grant", 64'(bus.grant), 64'b0001);
    for (int k = 2; k <= 16; k++) begin
      if (k == 5) bus.req = 4'b0101;
      tick();
      chk($sformatf("hold c%0d grant", k), 64'(bus.grant), 64'b0001);
      chk($sformatf("hold c%0d expired", k), 64'(bus.expired), 64'h0);
    end
    tick();
`ifdef ARB_HOLD_LIMIT_EN
    chk("evict grant", 64'(bus.grant), 64'b0100);
    chk("evict sel", 64'(bus.sel), 64'd2);
    chk("evict expired", 64'(bus.expired), 64'h1);
    chk("evict out_data", bus.out_data, W2);
    tick();
    chk("post_evict expired", 64'(bus.expired), 64'h0);
    chk("post_evict grant", 64'(bus.grant), 64'b0100);
`else
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("nolimit %0d grant", k), 64'(bus.grant), 64'b0001);
      chk($sformatf("nolimit %0d expired", k), 64'(bus.expired), 64'h0);
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
